// File: rtl/clint_pkg.sv
// Shared constants and types for the multi-hart core-local interruptor.
package clint_pkg;

  localparam int MAX_HARTS = 16;

  // Register offsets relative to the CLINT base address.
  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_LO_OFF = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF = 16'hBFFC;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } bus_state_e;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_MTIMECMP,
    REG_MTIME_LO,
    REG_MTIME_HI
  } reg_sel_e;

endpackage

// File: rtl/clint_timebase.sv
// Free-running 64-bit mtime counter with a clock prescaler and
// software load ports for each 32-bit half.
module clint_timebase #(
  parameter int PRESCALE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        time_en_i,
  input  logic        ld_lo_i,
  input  logic        ld_hi_i,
  input  logic [31:0] ld_data_i,
  output logic [63:0] mtime_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic          wrap;

  // Next-state: a software load overrides the tick and restarts the prescaler.
  always_comb begin
    wrap    = time_en_i && (presc_q == PS_MAX);
    presc_d = presc_q;
    mtime_d = mtime_q;
    if (ld_lo_i || ld_hi_i) begin
      presc_d = '0;
      if (ld_lo_i) mtime_d[31:0]  = ld_data_i;
      if (ld_hi_i) mtime_d[63:32] = ld_data_i;
    end else if (time_en_i) begin
      presc_d = wrap ? '0 : presc_q + 1'b1;
      if (wrap) mtime_d = mtime_q + 64'd1;
    end
  end

  // Prescaler and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

  assign mtime_o = mtime_q;

endmodule

// File: rtl/clint_multi.sv
// Multi-hart core-local interruptor: bus decode and response FSM,
// per-hart msip/mtimecmp, torn-read shadow for mtime, timer compare.
module clint_multi
  import clint_pkg::*;
#(
  parameter int                    NUM_HARTS  = 2,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0200_0000,
  parameter int                    PRESCALE   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ack,
  output logic                  err,
  input  logic                  time_en,
  output logic [63:0]           mtime_o,
  output logic [NUM_HARTS-1:0]  m_timer_irq,
  output logic [NUM_HARTS-1:0]  m_soft_irq
);

  bus_state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [NUM_HARTS-1:0] msip_q;
  logic [63:0]          mtimecmp_q [NUM_HARTS];
  logic [NUM_HARTS-1:0] timer_irq_q;
  logic [31:0]          shadow_q, shadow_d;
  logic                 shadow_valid_q, shadow_valid_d;

  logic [63:0] mtime;
  logic        ld_lo, ld_hi;

  logic [ADDR_WIDTH-1:0] off_full;
  logic [15:0]           off16;
  logic                  in_range;
  reg_sel_e              region;
  logic [13:0]           hart_raw;
  logic [NUM_HARTS-1:0]  hart_oh;
  logic                  acc_ok;
  logic                  cmp_hi;
  logic                  sel_msip;
  logic [63:0]           sel_cmp;

  logic [NUM_HARTS-1:0] msip_we, cmp_lo_we, cmp_hi_we;

  clint_timebase #(
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .clk_i     (clk),
    .rst_i     (rst),
    .time_en_i (time_en),
    .ld_lo_i   (ld_lo),
    .ld_hi_i   (ld_hi),
    .ld_data_i (wdata),
    .mtime_o   (mtime)
  );

  // Address decode: region, one-hot hart select and the selected hart's registers.
  always_comb begin
    off_full = addr - BASE_ADDR;
    off16    = off_full[15:0];
    in_range = (off_full[ADDR_WIDTH-1:16] == '0);
    region   = REG_NONE;
    hart_raw = '0;
    cmp_hi   = off16[2];
    if (in_range && (off16[1:0] == 2'b00)) begin
      if (off16 < MTIMECMP_OFF) begin
        region   = REG_MSIP;
        hart_raw = {2'b00, off16[15:2]};
      end else if (off16 < MTIME_LO_OFF) begin
        region   = REG_MTIMECMP;
        hart_raw = {1'b0, off16[15:3] - MTIMECMP_OFF[15:3]};
      end else if (off16 == MTIME_LO_OFF) begin
        region = REG_MTIME_LO;
      end else if (off16 == MTIME_HI_OFF) begin
        region = REG_MTIME_HI;
      end
    end
    hart_oh  = '0;
    sel_msip = 1'b0;
    sel_cmp  = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (32'(hart_raw) == h) hart_oh[h] = 1'b1;
      if (hart_oh[h]) begin
        sel_msip = msip_q[h];
        sel_cmp  = mtimecmp_q[h];
      end
    end
    acc_ok = (region == REG_MTIME_LO) || (region == REG_MTIME_HI) ||
             (((region == REG_MSIP) || (region == REG_MTIMECMP)) && (|hart_oh));
  end

  // Bus FSM: perform the access in IDLE, present the response in RESP.
  always_comb begin
    state_d        = state_q;
    rdata_d        = '0;
    err_d          = 1'b0;
    msip_we        = '0;
    cmp_lo_we      = '0;
    cmp_hi_we      = '0;
    ld_lo          = 1'b0;
    ld_hi          = 1'b0;
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
    case (state_q)
      IDLE: begin
        if (re || we) begin
          state_d = RESP;
          if (!acc_ok) begin
            err_d = 1'b1;
          end else if (we) begin
            case (region)
              REG_MSIP:     msip_we = hart_oh;
              REG_MTIMECMP: begin
                if (cmp_hi) cmp_hi_we = hart_oh;
                else        cmp_lo_we = hart_oh;
              end
              REG_MTIME_LO: begin
                ld_lo          = 1'b1;
                shadow_valid_d = 1'b0;
              end
              REG_MTIME_HI: begin
                ld_hi          = 1'b1;
                shadow_valid_d = 1'b0;
              end
              default: ;
            endcase
          end else begin
            case (region)
              REG_MSIP:     rdata_d = DATA_WIDTH'(sel_msip);
              REG_MTIMECMP: rdata_d = cmp_hi ? sel_cmp[63:32] : sel_cmp[31:0];
              REG_MTIME_LO: begin
                rdata_d        = mtime[31:0];
                shadow_d       = mtime[63:32];
                shadow_valid_d = 1'b1;
              end
              REG_MTIME_HI: begin
                rdata_d        = shadow_valid_q ? shadow_q : mtime[63:32];
                shadow_valid_d = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // mtime high-half shadow for torn-read-safe 32-bit reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
    end else begin
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
    end
  end

  // Per-hart software-interrupt bits and timer compare values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msip_q <= '0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp_q[h] <= '1;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (msip_we[h])   msip_q[h]             <= wdata[0];
        if (cmp_lo_we[h]) mtimecmp_q[h][31:0]  <= wdata;
        if (cmp_hi_we[h]) mtimecmp_q[h][63:32] <= wdata;
      end
    end
  end

  // Registered unsigned timer compare per hart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_irq_q <= '0;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) timer_irq_q[h] <= (mtime >= mtimecmp_q[h]);
    end
  end

  assign rdata       = rdata_q;
  assign err         = err_q;
  assign ack         = (state_q == RESP);
  assign mtime_o     = mtime;
  assign m_timer_irq = timer_irq_q;
  assign m_soft_irq  = msip_q;

endmodule

// File: tb/tb_clint_multi.sv
// Bench for clint_multi: table of single accesses plus hand sequences for
// timebase, torn reads, timer interrupt and reset during a response.
module tb_clint_multi;

  localparam int          NH = 2;
  localparam logic [31:0] B  = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic        we, re, ack, err, time_en;
  logic [63:0] mtime_o;
  logic [NH-1:0] m_timer_irq, m_soft_irq;

  clint_multi #(
    .NUM_HARTS (NH),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .BASE_ADDR (B),
    .PRESCALE  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .wdata      (wdata),
    .we         (we),
    .re         (re),
    .rdata      (rdata),
    .ack        (ack),
    .err        (err),
    .time_en    (time_en),
    .mtime_o    (mtime_o),
    .m_timer_irq(m_timer_irq),
    .m_soft_irq (m_soft_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       name;
  } vec_t;

  exp_t sb[$];
  vec_t vt[21];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One bus access: expectation queued at drive time, popped when ack is seen.
  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic ee, input string name);
    exp_t e;
    e.rdata = er;
    e.err   = ee;
    e.name  = name;
    sb.push_back(e);
    @(negedge clk);
    we = w; re = r; addr = a; wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0;
    check({name, " ack"}, 64'(ack), 64'd1);
    e = sb.pop_front();
    check({e.name, " rdata"}, 64'(rdata), 64'(e.rdata));
    check({e.name, " err"}, 64'(err), 64'(e.err));
    @(posedge clk);
    #1;
    check({name, " ack pulse"}, 64'(ack), 64'd0);
  endtask

  // Exactly n clock edges with time_en high, then freeze again.
  task automatic run(input int n);
    @(negedge clk);
    time_en = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    time_en = 1'b0;
  endtask

  initial begin
    vt[0]  = '{1'b0, 1'b1, B + 32'h0000, 32'h0, 32'h0,         1'b0, "rd msip0"};
    vt[1]  = '{1'b0, 1'b1, B + 32'h4000, 32'h0, 32'hFFFF_FFFF, 1'b0, "rd cmp0 lo"};
    vt[2]  = '{1'b0, 1'b1, B + 32'h4004, 32'h0, 32'hFFFF_FFFF, 1'b0, "rd cmp0 hi"};
    vt[3]  = '{1'b0, 1'b1, B + 32'hBFF8, 32'h0, 32'h0,         1'b0, "rd mtime lo"};
    vt[4]  = '{1'b0, 1'b1, B + 32'hBFFC, 32'h0, 32'h0,         1'b0, "rd mtime hi"};
    vt[5]  = '{1'b1, 1'b0, B + 32'h0004, 32'h3, 32'h0,         1'b0, "wr msip1"};
    vt[6]  = '{1'b0, 1'b1, B + 32'h0004, 32'h0, 32'h1,         1'b0, "rd msip1"};
    vt[7]  = '{1'b0, 1'b1, B + 32'h0008, 32'h0, 32'h0,         1'b1, "rd msip hart2"};
    vt[8]  = '{1'b0, 1'b1, B + 32'h4001, 32'h0, 32'h0,         1'b1, "rd misaligned"};
    vt[9]  = '{1'b0, 1'b1, B + 32'h4010, 32'h0, 32'h0,         1'b1, "rd cmp hart2"};
    vt[10] = '{1'b0, 1'b1, B + 32'hC000, 32'h0, 32'h0,         1'b1, "rd unmapped"};
    vt[11] = '{1'b0, 1'b1, 32'h01FF_FFFC, 32'h0, 32'h0,        1'b1, "rd below base"};
    vt[12] = '{1'b1, 1'b0, B + 32'h0006, 32'h0, 32'h0,         1'b1, "wr misaligned"};
    vt[13] = '{1'b1, 1'b0, B + 32'h4008, 32'h1234_5678, 32'h0, 1'b0, "wr cmp1 lo"};
    vt[14] = '{1'b0, 1'b1, B + 32'h4008, 32'h0, 32'h1234_5678, 1'b0, "rd cmp1 lo"};
    vt[15] = '{1'b0, 1'b1, B + 32'h400C, 32'h0, 32'hFFFF_FFFF, 1'b0, "rd cmp1 hi"};
    vt[16] = '{1'b1, 1'b1, B + 32'h0000, 32'h1, 32'h0,         1'b0, "re+we msip0"};
    vt[17] = '{1'b0, 1'b1, B + 32'h0000, 32'h0, 32'h1,         1'b0, "rd msip0 after re+we"};
    vt[18] = '{1'b1, 1'b0, B + 32'h0000, 32'hFFFF_FFFE, 32'h0, 1'b0, "wr msip0 upper bits"};
    vt[19] = '{1'b0, 1'b1, B + 32'h0000, 32'h0, 32'h0,         1'b0, "rd msip0 cleared"};
    vt[20] = '{1'b0, 1'b1, B + 32'h0004, 32'h0, 32'h1,         1'b0, "rd msip1 kept"};

    rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; time_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ack", 64'(ack), 64'd0);
    check("reset rdata", 64'(rdata), 64'd0);
    check("reset err", 64'(err), 64'd0);
    check("reset mtime", mtime_o, 64'd0);
    check("reset timer irq", 64'(m_timer_irq), 64'd0);
    check("reset soft irq", 64'(m_soft_irq), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++)
      access(vt[i].w, vt[i].r, vt[i].a, vt[i].d, vt[i].exp_rd, vt[i].exp_err, vt[i].name);
    check("soft irq after table", 64'(m_soft_irq), 64'h2);
    check("timer irq after table", 64'(m_timer_irq), 64'h0);

    // Prescale by 4: 40 enabled cycles give 10 ticks; disabled cycles hold.
    run(40);
    check("mtime after 40 cycles", mtime_o, 64'd10);
    repeat (8) @(negedge clk);
    check("mtime frozen", mtime_o, 64'd10);

    // Timer compare at mtime+5.
    access(1'b1, 1'b0, B + 32'h4004, 32'h0, 32'h0, 1'b0, "wr cmp0 hi 0");
    access(1'b1, 1'b0, B + 32'h4000, 32'd15, 32'h0, 1'b0, "wr cmp0 lo 15");
    check("timer irq below cmp", 64'(m_timer_irq), 64'h0);
    @(negedge clk);
    time_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mtime_o >= 64'd15) break;
    end
    check("mtime reached cmp", mtime_o, 64'd15);
    check("timer irq same cycle", 64'(m_timer_irq), 64'h0);
    @(negedge clk);
    time_en = 1'b0;
    check("timer irq next cycle", 64'(m_timer_irq), 64'h1);
    access(1'b1, 1'b0, B + 32'h4004, 32'hFFFF_FFFF, 32'h0, 1'b0, "wr cmp0 hi ones");
    check("timer irq cleared", 64'(m_timer_irq), 64'h0);

    // Carry from lo into hi.
    access(1'b1, 1'b0, B + 32'hBFFC, 32'h0, 32'h0, 1'b0, "wr mtime hi 0");
    access(1'b1, 1'b0, B + 32'hBFF8, 32'hFFFF_FFF0, 32'h0, 1'b0, "wr mtime lo");
    check("mtime loaded", mtime_o, 64'h0000_0000_FFFF_FFF0);
    run(64);
    check("mtime carry", mtime_o, 64'h0000_0001_0000_0000);

    // Torn-read protection across a carry.
    access(1'b1, 1'b0, B + 32'hBFFC, 32'h0, 32'h0, 1'b0, "wr mtime hi 0b");
    access(1'b1, 1'b0, B + 32'hBFF8, 32'hFFFF_FFFF, 32'h0, 1'b0, "wr mtime lo ones");
    access(1'b0, 1'b1, B + 32'hBFF8, 32'h0, 32'hFFFF_FFFF, 1'b0, "rd mtime lo pre-carry");
    run(4);
    check("mtime after tick", mtime_o, 64'h0000_0001_0000_0000);
    access(1'b0, 1'b1, B + 32'hBFFC, 32'h0, 32'h0, 1'b0, "rd mtime hi shadow");
    access(1'b0, 1'b1, B + 32'hBFFC, 32'h0, 32'h1, 1'b0, "rd mtime hi live");
    access(1'b0, 1'b1, B + 32'hBFF8, 32'h0, 32'h0, 1'b0, "rd mtime lo capture");
    access(1'b1, 1'b0, B + 32'hBFFC, 32'h7, 32'h0, 1'b0, "wr mtime hi 7");
    access(1'b0, 1'b1, B + 32'hBFFC, 32'h0, 32'h7, 1'b0, "rd mtime hi after write");
    check("mtime hi written", mtime_o, 64'h0000_0007_0000_0000);

    // A write mid-prescale restarts the prescaler.
    run(2);
    access(1'b1, 1'b0, B + 32'hBFF8, 32'h100, 32'h0, 1'b0, "wr mtime lo mid-prescale");
    run(3);
    check("prescaler restarted", mtime_o, 64'h0000_0007_0000_0100);
    run(1);
    check("tick after restart", mtime_o, 64'h0000_0007_0000_0101);

    // 64-bit wrap.
    access(1'b1, 1'b0, B + 32'hBFFC, 32'hFFFF_FFFF, 32'h0, 1'b0, "wr mtime hi max");
    access(1'b1, 1'b0, B + 32'hBFF8, 32'hFFFF_FFFF, 32'h0, 1'b0, "wr mtime lo max");
    run(4);
    check("mtime wrap", mtime_o, 64'h0);

    // Reset while a response is being presented.
    @(negedge clk);
    re = 1'b1; addr = B + 32'h4000;
    @(posedge clk);
    #1;
    re = 1'b0;
    check("pre-reset ack", 64'(ack), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("reset mid ack", 64'(ack), 64'd0);
    check("reset mid rdata", 64'(rdata), 64'd0);
    check("reset mid soft irq", 64'(m_soft_irq), 64'd0);
    check("reset mid mtime", mtime_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("no ack after reset", 64'(ack), 64'd0);
    access(1'b0, 1'b1, B + 32'h4008, 32'h0, 32'hFFFF_FFFF, 1'b0, "rd cmp1 lo reset");
    access(1'b0, 1'b1, B + 32'h0004, 32'h0, 32'h0, 1'b0, "rd msip1 reset");
    access(1'b0, 1'b1, B + 32'hBFFC, 32'h0, 32'h0, 1'b0, "rd mtime hi reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
